// File: rtl/byp_seq_ctrl.sv
// Bypass contactor sequencer: arbitrates master close command vs. fiber-fault auto-bypass,
// drives the coil and supervises the debounced aux contact. Auto-bypass path enabled by BYP_AUTO_EN.
module byp_seq_ctrl #(
  parameter int FB_DEB   = 200,
  parameter int FB_TMO   = 50000,
  parameter int HOLD_MIN = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        time_1us,
  input  logic        reset_unit,
  input  logic        byp_req,
  input  logic        fiber_delay_err,
  input  logic        fiber_verify_err,
  input  logic [13:0] delay_tims,
  input  logic        byp_fb,
  output logic        byp_con,
  output logic        byp_closed,
  output logic        byp_fail,
  output logic [2:0]  byp_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DELAY   = 3'd1,
    CLOSING = 3'd2,
    CLOSED  = 3'd3,
    OPENING = 3'd4,
    FAIL    = 3'd5
  } state_t;

  localparam logic [15:0] DEB_LAST = 16'(FB_DEB - 1);
  localparam logic [15:0] TMO_C    = 16'(FB_TMO);
  localparam logic [15:0] HOLD_C   = 16'(HOLD_MIN);

  logic [1:0]  t_sync;
  logic [1:0]  fb_sync;
  logic        tick;
  logic        fb_stable;
  logic [15:0] deb_cnt;
  logic [15:0] cnt;
  state_t      state;
  state_t      nxt;
  logic        auto_src;
  logic        auto_nxt;
  logic        err;
  logic [13:0] dly;

`ifdef BYP_AUTO_EN
  assign err = fiber_delay_err | fiber_verify_err;
  assign dly = delay_tims;
`else
  // Master-only build: fiber error inputs are deliberately left dangling.
  logic unused_auto;
  assign unused_auto = ^{fiber_delay_err, fiber_verify_err, delay_tims};
  assign err = 1'b0;
  assign dly = '0;
`endif

  // t_sync[1] is the older sample, so 2'b01 marks a rising timebase edge.
  assign tick      = (t_sync == 2'b01);
  assign byp_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_sync    <= '0;
      fb_sync   <= '0;
      fb_stable <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      t_sync  <= {t_sync[0], time_1us};
      fb_sync <= {fb_sync[0], byp_fb};
      if (tick) begin
        if (fb_sync[1] != fb_stable) begin
          if (deb_cnt == DEB_LAST) begin
            fb_stable <= fb_sync[1];
            deb_cnt   <= '0;
          end else begin
            deb_cnt <= deb_cnt + 16'd1;
          end
        end else begin
          deb_cnt <= '0;
        end
      end
    end
  end

  always_comb begin
    nxt      = state;
    auto_nxt = auto_src;
    if (reset_unit) begin
      nxt      = IDLE;
      auto_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (byp_req) begin
            nxt      = CLOSING;
            auto_nxt = 1'b0;
          end else if (err) begin
            nxt = DELAY;
          end
        end
        DELAY: begin
          if (byp_req) begin
            nxt      = CLOSING;
            auto_nxt = 1'b0;
          end else if (!err) begin
            nxt = IDLE;
          end else if (cnt >= {2'b00, dly}) begin
            nxt      = CLOSING;
            auto_nxt = 1'b1;
          end
        end
        CLOSING: begin
          if (fb_stable)            nxt = CLOSED;
          else if (cnt >= TMO_C)    nxt = FAIL;
        end
        CLOSED: begin
          // An auto-bypass closure latches until the master resets the unit.
          if (!fb_stable)                                     nxt = FAIL;
          else if (!auto_src && !byp_req && cnt >= HOLD_C)    nxt = OPENING;
        end
        OPENING: begin
          if (!fb_stable)           nxt = IDLE;
          else if (cnt >= TMO_C)    nxt = FAIL;
        end
        FAIL: nxt = FAIL;
        default: begin
          nxt      = IDLE;
          auto_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      auto_src   <= 1'b0;
      cnt        <= '0;
      byp_con    <= 1'b0;
      byp_closed <= 1'b0;
      byp_fail   <= 1'b0;
    end else begin
      state    <= nxt;
      auto_src <= auto_nxt;
      if (reset_unit || (nxt != state)) cnt <= '0;
      else if (tick && (cnt != 16'hFFFF)) cnt <= cnt + 16'd1;
      byp_con    <= (nxt == CLOSING) || (nxt == CLOSED);
      byp_closed <= (nxt == CLOSED);
      byp_fail   <= (nxt == FAIL);
    end
  end

endmodule

// File: tb/tb_byp_seq_ctrl.sv
// Self-checking bench for byp_seq_ctrl: directed scenarios plus random stimulus,
// every cycle compared against a behavioural model of the sequencing rules.
module tb_byp_seq_ctrl;

  localparam int FB_DEB   = 4;
  localparam int FB_TMO   = 100;
  localparam int HOLD_MIN = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        time_1us = 1'b0;
  logic        reset_unit = 1'b0;
  logic        byp_req = 1'b0;
  logic        fiber_delay_err = 1'b0;
  logic        fiber_verify_err = 1'b0;
  logic [13:0] delay_tims = 14'd0;
  logic        byp_fb = 1'b0;
  logic        byp_con;
  logic        byp_closed;
  logic        byp_fail;
  logic [2:0]  byp_state;

  int checks = 0;
  int errors = 0;

  byp_seq_ctrl #(.FB_DEB(FB_DEB), .FB_TMO(FB_TMO), .HOLD_MIN(HOLD_MIN)) dut (
    .clk(clk), .rst(rst), .time_1us(time_1us), .reset_unit(reset_unit),
    .byp_req(byp_req), .fiber_delay_err(fiber_delay_err),
    .fiber_verify_err(fiber_verify_err), .delay_tims(delay_tims),
    .byp_fb(byp_fb), .byp_con(byp_con), .byp_closed(byp_closed),
    .byp_fail(byp_fail), .byp_state(byp_state)
  );

  always #5 clk = ~clk;

  // 1 us timebase: high for 2 clk out of every 10.
  initial begin
    forever begin
      repeat (8) @(negedge clk);
      time_1us = 1'b1;
      repeat (2) @(negedge clk);
      time_1us = 1'b0;
    end
  end

  // Behavioural model: input history windows, ticks spent in the current phase, debounce run length.
  int m_state, m_ticks, m_run;
  bit m_auto, m_stab, m_err, m_tick;
  bit t_hist [2];
  bit f_hist [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_ticks = 0; m_run = 0; m_auto = 0; m_stab = 0;
      t_hist[0] = 0; t_hist[1] = 0; f_hist[0] = 0; f_hist[1] = 0;
    end else begin
      int ns;
      bit na;
      bit fbs;
      m_tick = !t_hist[1] && t_hist[0];
      fbs    = f_hist[1];
`ifdef BYP_AUTO_EN
      m_err = fiber_delay_err || fiber_verify_err;
`else
      m_err = 0;
`endif
      ns = m_state;
      na = m_auto;
      if (reset_unit) begin
        ns = 0; na = 0;
      end else begin
        case (m_state)
          0: if (byp_req) begin ns = 2; na = 0; end
             else if (m_err) ns = 1;
          1: if (byp_req) begin ns = 2; na = 0; end
             else if (!m_err) ns = 0;
             else if (m_ticks >= int'(delay_tims)) begin ns = 2; na = 1; end
          2: if (m_stab) ns = 3; else if (m_ticks >= FB_TMO) ns = 5;
          3: if (!m_stab) ns = 5;
             else if (!m_auto && !byp_req && m_ticks >= HOLD_MIN) ns = 4;
          4: if (!m_stab) ns = 0; else if (m_ticks >= FB_TMO) ns = 5;
          default: ;
        endcase
      end
      if (reset_unit || ns != m_state) m_ticks = 0;
      else if (m_tick && m_ticks < 65535) m_ticks++;
      m_state = ns;
      m_auto  = na;
      if (m_tick) begin
        if (fbs != m_stab) begin
          m_run++;
          if (m_run == FB_DEB) begin m_stab = fbs; m_run = 0; end
        end else begin
          m_run = 0;
        end
      end
      t_hist[1] = t_hist[0]; t_hist[0] = time_1us;
      f_hist[1] = f_hist[0]; f_hist[0] = byp_fb;
    end
  end

  // Per-cycle comparison against the model.
  int printed = 0;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      logic [5:0] act, exp;
      act = {byp_con, byp_closed, byp_fail, byp_state};
      exp = {(m_state == 2 || m_state == 3), (m_state == 3), (m_state == 5), 3'(m_state)};
      checks++;
      if (act !== exp) begin
        errors++;
        if (printed < 20) begin
          printed++;
          $display("FAIL model_cmp t=%0t con/closed/fail/state actual=%b expected=%b", $time, act, exp);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s actual=%0d expected %0d..%0d", nm, v, lo, hi);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input string nm, input logic [2:0] s, input int bound);
    int n = 0;
    while (byp_state !== s && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(nm, byp_state, s);
  endtask

  task automatic unit_reset();
    reset_unit = 1'b1;
    @(negedge clk);
    reset_unit = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // reset
    @(negedge clk);
    chk("rst_state", byp_state, 0);
    chk("rst_outs", {byp_con, byp_closed, byp_fail}, 0);
    clks(2);
    rst = 1'b0;
    clks(5);

    // master close then master open
    byp_req = 1'b1;
    @(negedge clk);
    chk("close_con_next", byp_con, 1);
    chk("close_state", byp_state, 2);
    clks(3);
    byp_fb = 1'b1;
    wait_state("close_reach_closed", 3'd3, 200);
    chk("close_closed_flag", byp_closed, 1);
    clks(150);
    byp_req = 1'b0;
    @(negedge clk);
    chk("open_state", byp_state, 4);
    chk("open_con", byp_con, 0);
    byp_fb = 1'b0;
    wait_state("open_to_idle", 3'd0, 200);

    // feedback timeout
    byp_req = 1'b1;
    n = 0;
    while (byp_fail !== 1'b1 && n < 1300) begin @(negedge clk); n++; end
    chk_rng("tmo_clks", n, 990, 1015);
    chk("tmo_state", byp_state, 5);
    chk("tmo_con", byp_con, 0);
    byp_req = 1'b0;
    clks(3);
    unit_reset();
    chk("tmo_ru_state", byp_state, 0);
    chk("tmo_ru_fail", byp_fail, 0);

    // feedback glitches in CLOSED
    byp_req = 1'b1;
    byp_fb = 1'b1;
    wait_state("glitch_closed", 3'd3, 200);
    clks(20);
    byp_fb = 1'b0; clks(30); byp_fb = 1'b1;
    clks(100);
    chk("glitch3_stays", byp_state, 3);
    byp_fb = 1'b0; clks(40); byp_fb = 1'b1;
    clks(20);
    chk("glitch4_fail", byp_state, 5);
    byp_req = 1'b0;
    unit_reset();
    byp_fb = 1'b0;
    clks(80);

    // early open request honoured only after hold time
    byp_req = 1'b1;
    byp_fb = 1'b1;
    wait_state("early_closed", 3'd3, 200);
    clks(30);
    byp_req = 1'b0;
    clks(50);
    chk("early_hold", byp_state, 3);
    chk("early_con", byp_con, 1);
    clks(40);
    chk("early_opening", byp_state, 4);
    byp_fb = 1'b0;
    wait_state("early_idle", 3'd0, 200);

    // async rst mid-CLOSING
    byp_req = 1'b1;
    clks(50);
    chk("arst_pre", byp_state, 2);
    #3 rst = 1'b1;
    #1;
    chk("arst_outs", {byp_con, byp_closed, byp_fail}, 0);
    chk("arst_state", byp_state, 0);
    byp_req = 1'b0;
    clks(3);
    rst = 1'b0;
    clks(5);

`ifdef BYP_AUTO_EN
    // auto-bypass after error persistence
    delay_tims = 14'd20;
    fiber_verify_err = 1'b1;
    n = 0;
    while (byp_con !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    chk_rng("auto_delay_clks", n, 190, 215);
    byp_fb = 1'b1;
    wait_state("auto_closed", 3'd3, 200);
    fiber_verify_err = 1'b0;
    clks(300);
    chk("auto_latched", byp_state, 3);
    chk("auto_latched_con", byp_con, 1);
    unit_reset();
    chk("auto_ru", byp_state, 0);
    byp_fb = 1'b0;
    clks(80);
    // error drops before persistence expires
    fiber_delay_err = 1'b1;
    clks(150);
    chk("auto_drop_delay", byp_state, 1);
    fiber_delay_err = 1'b0;
    clks(100);
    chk("auto_drop_idle", byp_state, 0);
    chk("auto_drop_con", byp_con, 0);
`endif

    // randomized segments
    for (int seg = 0; seg < 40; seg++) begin
      byp_req          = 1'($urandom_range(0, 1));
      byp_fb           = 1'($urandom_range(0, 1));
      fiber_delay_err  = ($urandom_range(0, 3) == 0);
      fiber_verify_err = ($urandom_range(0, 3) == 0);
      delay_tims       = 14'($urandom_range(0, 30));
      if ($urandom_range(0, 3) == 0) unit_reset();
      clks($urandom_range(1, 300));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byp_seq_ctrl.md
Name: byp_seq_ctrl

Overview:
Sequencer for the power-unit bypass contactor. It arbitrates between the master-controller bypass command and the local fiber-fault auto-bypass request. It drives the contactor coil, supervises the auxiliary feedback contact with debounce and timeouts, and reports closed/fail status to the unit-board status word. It sits between the fiber-frame decoder (command, fiber error flags) and the contactor driver pin.

Parameters:
FB_DEB, 200, feedback debounce length in 1 us ticks
FB_TMO, 50000, max ticks to see feedback change after a coil command (50 ms)
HOLD_MIN, 10000, minimum closed time in ticks before a master-initiated open is honoured (10 ms)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
time_1us  in  1  1 us timebase from the prescaler, async to use, level >=2 clk wide
reset_unit  in  1  synchronous unit reset from the master frame, active-high
byp_req  in  1  master bypass command (1 = close), already in clk domain
fiber_delay_err  in  1  fiber frame delay error
fiber_verify_err  in  1  fiber frame CRC/verify error
delay_tims  in  14  fiber-error persistence required before auto-bypass, in ticks
byp_fb  in  1  contactor auxiliary contact, asynchronous, 1 = closed
byp_con  out  1  contactor coil drive, registered
byp_closed  out  1  contactor confirmed closed, registered
byp_fail  out  1  sequencing failure latched, registered
byp_state  out  3  current FSM state code, for diagnostics

Behaviour:
- Reset (rst=1): all state, counters and sync flops cleared. State=IDLE, byp_con=0, byp_closed=0, byp_fail=0, byp_state=0.
- tick: time_1us passes through a 2-FF sync. tick is a 1-clk pulse when the sync pair equals 2'b01. All timers advance only on tick.
- byp_fb passes through a 2-FF sync. fb_stable updates to the synced value only after it has differed from fb_stable for FB_DEB consecutive ticks. Any mismatch-free tick clears the debounce counter. fb_stable resets to 0.
- err = fiber_delay_err | fiber_verify_err.
- One 16-bit tick counter is shared by all states. It clears on every state transition and saturates at 16'hFFFF.
- FSM states: registered outputs are updated on the same edge as the state register. byp_con follows 1 clk after the input that causes the transition.
  - IDLE(0): byp_con=0. byp_req=1 -> CLOSING, auto_src=0. Otherwise, err=1 and auto-bypass enabled -> DELAY. byp_req has priority.
  - DELAY(1): byp_con=0. byp_req=1 -> CLOSING, auto_src=0. err=0 -> IDLE. Counter >= delay_tims -> CLOSING, auto_src=1. delay_tims=0 gives DELAY for exactly 1 clk.
  - CLOSING(2): byp_con=1. fb_stable=1 -> CLOSED. Counter reaches FB_TMO -> FAIL.
  - CLOSED(3): byp_con=1, byp_closed=1. fb_stable falls to 0 -> FAIL. If auto_src=0, byp_req=0 and counter >= HOLD_MIN -> OPENING. If auto_src=1, stays closed until reset_unit, and byp_req is ignored.
  - OPENING(4): byp_con=0. fb_stable=0 -> IDLE. Counter reaches FB_TMO -> FAIL. byp_req=1 here is ignored until IDLE is reached.
  - FAIL(5): byp_con=0, byp_fail=1. Exits only via reset_unit or rst.
- reset_unit=1 (synchronous): forces IDLE, clears counters and auto_src, and deasserts byp_con/byp_closed/byp_fail on the next edge. It wins over every other input in the same cycle. The debounce state is kept.
- reset_unit or rst while in CLOSED drops the coil. The master must re-issue byp_req to reclose.
- Unused state codes 6 and 7 recover to IDLE on the next clk.

Optional Feature:
Macro: BYP_AUTO_EN.
- Defined: the IDLE->DELAY->CLOSING fiber-error auto-bypass path is present as described.
- Undefined: err is ignored, DELAY is unreachable, and only byp_req can close the contactor. delay_tims, fiber_delay_err and fiber_verify_err are left unconnected internally. This is the default build: coil closure is commanded by the master only.

Test Plan:
Bench settings are FB_DEB=4, FB_TMO=100, HOLD_MIN=10, with a tick every 10 clk.
- Master close: byp_req=1 from IDLE -> byp_con=1 the next clk. byp_fb=1 held 4 ticks -> byp_closed=1, state=3. byp_req=0 after 10 ticks -> byp_con=0, fb=0 -> IDLE.
- Feedback timeout: byp_req=1, byp_fb held 0 -> after 100 ticks byp_fail=1, byp_con=0, state=5. reset_unit pulse -> IDLE, byp_fail=0.
- Feedback glitch: in CLOSED, byp_fb drops for 3 ticks -> stays CLOSED. A drop for 4 ticks -> FAIL.
- Auto-bypass (BYP_AUTO_EN): fiber_verify_err=1 with delay_tims=20 -> byp_con=1 after about 20 ticks. An err drop at tick 15 -> IDLE with no coil. Once closed, byp_req=0 keeps byp_con=1 until reset_unit.
- Early open request: close, then byp_req=0 at tick 3 of CLOSED -> byp_con stays 1 until counter=10, then OPENING.
- Async rst asserted mid-CLOSING -> all outputs 0 immediately, without a clock edge.
